// File: rtl/kway_sort_node.sv
// kway_sort_node: one level of a pipelined K-way heap.
// The node compares an element handed down from the level above with its
// FANOUT children in child memory. If the best child beats the element,
// the two swap and the displaced element is pushed to the next level.
// An INIT sequence fills this level's child memory with sentinels.
module kway_sort_node #(
  parameter int DATA_WIDTH = 32,
  parameter int KEY_WIDTH  = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int FANOUT     = 4,
  parameter int LEVEL      = 1,
  parameter int MAX_HEAP   = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         init,
  output logic                         init_done,
  output logic                         busy,
  output logic                         ovf,
  input  logic                         pl_update_in,
  input  logic [ADDR_WIDTH-1:0]        pl_idx_in,
  input  logic [DATA_WIDTH-1:0]        pl_in,
  output logic                         pl_update_out,
  output logic [ADDR_WIDTH-1:0]        pl_idx_out,
  output logic [DATA_WIDTH-1:0]        pl_out,
  output logic [ADDR_WIDTH-1:0]        cm_addr,
  input  logic [FANOUT*DATA_WIDTH-1:0] cm_rdata,
  output logic [FANOUT-1:0]            cm_we,
  output logic [DATA_WIDTH-1:0]        cm_wdata,
  input  logic                         nl_update_in,
  input  logic [ADDR_WIDTH-1:0]        nl_idx_in,
  input  logic [DATA_WIDTH-1:0]        nl_in,
  output logic                         nl_update_out,
  output logic [ADDR_WIDTH-1:0]        nl_idx_out,
  output logic [DATA_WIDTH-1:0]        nl_out
);

  localparam int SW   = $clog2(FANOUT);
  localparam int ROWS = FANOUT ** LEVEL;
  localparam logic [ADDR_WIDTH-1:0] LAST_ROW = ADDR_WIDTH'(ROWS - 1);
  localparam logic [DATA_WIDTH-1:0] INIT_DATA = (MAX_HEAP != 0) ?
      {2'b01, {(DATA_WIDTH-2){1'b0}}} : {2'b11, {(DATA_WIDTH-2){1'b0}}};
  localparam logic [FANOUT-1:0] ONE_HOT0 = {{(FANOUT-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE = 2'd0, INIT = 2'd1, CMP = 2'd2, WB = 2'd3} state_t;

  // Rank of the flag field: min sentinel 0, normal 1, max sentinel 2 (10 acts as 11).
  function automatic logic [1:0] rank(input logic [DATA_WIDTH-1:0] e);
    logic [1:0] f;
    f = e[DATA_WIDTH-1:DATA_WIDTH-2];
    if (f == 2'b01) begin
      rank = 2'd0;
    end else if (f == 2'b00) begin
      rank = 2'd1;
    end else begin
      rank = 2'd2;
    end
  endfunction

  // Strict ordering; only two normal entries fall through to the key compare.
  function automatic logic less(input logic [DATA_WIDTH-1:0] a,
                                input logic [DATA_WIDTH-1:0] b);
    logic [1:0] ra, rb;
    ra = rank(a);
    rb = rank(b);
    if (ra != rb) begin
      less = (ra < rb);
    end else if (ra == 2'd1) begin
      less = (a[KEY_WIDTH-1:0] < b[KEY_WIDTH-1:0]);
    end else begin
      less = 1'b0;
    end
  endfunction

  // "a should sit above b" for this heap direction.
  function automatic logic better(input logic [DATA_WIDTH-1:0] a,
                                  input logic [DATA_WIDTH-1:0] b);
    if (MAX_HEAP != 0) begin
      better = less(b, a);
    end else begin
      better = less(a, b);
    end
  endfunction

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   row_r;
  logic [ADDR_WIDTH-1:0]   addr_r;
  logic [ADDR_WIDTH-1:0]   idx_r;
  logic [DATA_WIDTH-1:0]   pl_r;
  logic                    byp_valid_r;
  logic [ADDR_WIDTH-1:0]   byp_idx_r;
  logic [DATA_WIDTH-1:0]   byp_data_r;

  logic [DATA_WIDTH-1:0]   slot_val [FANOUT];
  logic [DATA_WIDTH-1:0]   best_val;
  logic [SW-1:0]           best_slot;
  logic                    swap;
  logic                    take;
  logic                    accept_pl;

  assign accept_pl = (state == IDLE) && pl_update_in && !init;

  // The memory read has one cycle of latency, so the row address must reach
  // the memory in the same cycle the element arrives; otherwise it is registered.
  assign cm_addr = accept_pl ? pl_idx_in : addr_r;

  // Assemble the child row, overlaying write-backs the memory read may have missed.
  always_comb begin
    for (int s = 0; s < FANOUT; s++) begin
      if (nl_update_in && ((nl_idx_in >> SW) == idx_r) && (nl_idx_in[SW-1:0] == SW'(s))) begin
        slot_val[s] = nl_in;
      end else if (byp_valid_r && ((byp_idx_r >> SW) == idx_r) &&
                   (byp_idx_r[SW-1:0] == SW'(s))) begin
        slot_val[s] = byp_data_r;
      end else begin
        slot_val[s] = cm_rdata[s*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Pick the best child (lowest slot wins ties) and decide whether to swap.
  always_comb begin
    best_val  = slot_val[0];
    best_slot = {SW{1'b0}};
    take      = 1'b0;
    for (int s = 1; s < FANOUT; s++) begin
      take      = better(slot_val[s], best_val);
      best_val  = take ? slot_val[s] : best_val;
      best_slot = take ? SW'(s) : best_slot;
    end
    swap = better(best_val, pl_r);
  end

  // Control FSM with all registered outputs, plus the write-back bypass register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      busy          <= 1'b0;
      init_done     <= 1'b0;
      ovf           <= 1'b0;
      row_r         <= {ADDR_WIDTH{1'b0}};
      addr_r        <= {ADDR_WIDTH{1'b0}};
      idx_r         <= {ADDR_WIDTH{1'b0}};
      pl_r          <= {DATA_WIDTH{1'b0}};
      byp_valid_r   <= 1'b0;
      byp_idx_r     <= {ADDR_WIDTH{1'b0}};
      byp_data_r    <= {DATA_WIDTH{1'b0}};
      pl_update_out <= 1'b0;
      pl_idx_out    <= {ADDR_WIDTH{1'b0}};
      pl_out        <= {DATA_WIDTH{1'b0}};
      cm_we         <= {FANOUT{1'b0}};
      cm_wdata      <= {DATA_WIDTH{1'b0}};
      nl_update_out <= 1'b0;
      nl_idx_out    <= {ADDR_WIDTH{1'b0}};
      nl_out        <= {DATA_WIDTH{1'b0}};
    end else begin
      byp_valid_r <= nl_update_in;
      byp_idx_r   <= nl_idx_in;
      byp_data_r  <= nl_in;

      if (pl_update_in && (state != IDLE)) begin
        ovf <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (init) begin
            state     <= INIT;
            busy      <= 1'b1;
            row_r     <= {ADDR_WIDTH{1'b0}};
            addr_r    <= {ADDR_WIDTH{1'b0}};
            cm_we     <= {FANOUT{1'b1}};
            cm_wdata  <= INIT_DATA;
            init_done <= (LAST_ROW == {ADDR_WIDTH{1'b0}});
          end else if (pl_update_in) begin
            state  <= CMP;
            busy   <= 1'b1;
            pl_r   <= pl_in;
            idx_r  <= pl_idx_in;
            addr_r <= pl_idx_in;
          end
        end
        INIT: begin
          if (row_r == LAST_ROW) begin
            state     <= IDLE;
            busy      <= 1'b0;
            cm_we     <= {FANOUT{1'b0}};
            init_done <= 1'b0;
          end else begin
            row_r     <= row_r + ADDR_WIDTH'(1);
            addr_r    <= row_r + ADDR_WIDTH'(1);
            init_done <= ((row_r + ADDR_WIDTH'(1)) == LAST_ROW);
          end
        end
        CMP: begin
          state <= WB;
          if (swap) begin
            pl_update_out <= 1'b1;
            pl_out        <= best_val;
            pl_idx_out    <= idx_r;
            cm_we         <= ONE_HOT0 << best_slot;
            cm_wdata      <= pl_r;
            nl_update_out <= 1'b1;
            nl_out        <= pl_r;
            nl_idx_out    <= (idx_r << SW) | ADDR_WIDTH'(best_slot);
          end else begin
            pl_update_out <= 1'b0;
            nl_update_out <= 1'b0;
            cm_we         <= {FANOUT{1'b0}};
          end
        end
        WB: begin
          state         <= IDLE;
          busy          <= 1'b0;
          pl_update_out <= 1'b0;
          nl_update_out <= 1'b0;
          cm_we         <= {FANOUT{1'b0}};
        end
        default: begin
          state         <= IDLE;
          busy          <= 1'b0;
          init_done     <= 1'b0;
          pl_update_out <= 1'b0;
          nl_update_out <= 1'b0;
          cm_we         <= {FANOUT{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_kway_sort_node.sv
// Directed testbench for kway_sort_node (FANOUT=4, LEVEL=1, min-heap).
module tb_kway_sort_node;

  logic         clk = 1'b0;
  logic         rst;
  logic         init;
  logic         init_done;
  logic         busy;
  logic         ovf;
  logic         pl_update_in;
  logic [7:0]   pl_idx_in;
  logic [31:0]  pl_in;
  logic         pl_update_out;
  logic [7:0]   pl_idx_out;
  logic [31:0]  pl_out;
  logic [7:0]   cm_addr;
  logic [127:0] cm_rdata;
  logic [3:0]   cm_we;
  logic [31:0]  cm_wdata;
  logic         nl_update_in;
  logic [7:0]   nl_idx_in;
  logic [31:0]  nl_in;
  logic         nl_update_out;
  logic [7:0]   nl_idx_out;
  logic [31:0]  nl_out;

  int n_cmp = 0;
  int n_err = 0;

  kway_sort_node #(
    .DATA_WIDTH(32), .KEY_WIDTH(16), .ADDR_WIDTH(8),
    .FANOUT(4), .LEVEL(1), .MAX_HEAP(0)
  ) dut (
    .clk(clk), .rst(rst), .init(init), .init_done(init_done), .busy(busy), .ovf(ovf),
    .pl_update_in(pl_update_in), .pl_idx_in(pl_idx_in), .pl_in(pl_in),
    .pl_update_out(pl_update_out), .pl_idx_out(pl_idx_out), .pl_out(pl_out),
    .cm_addr(cm_addr), .cm_rdata(cm_rdata), .cm_we(cm_we), .cm_wdata(cm_wdata),
    .nl_update_in(nl_update_in), .nl_idx_in(nl_idx_in), .nl_in(nl_in),
    .nl_update_out(nl_update_out), .nl_idx_out(nl_idx_out), .nl_out(nl_out)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ent(input logic [15:0] k);
    return {16'h0000, k};
  endfunction

  function automatic logic [127:0] row(input logic [31:0] e0, input logic [31:0] e1,
                                       input logic [31:0] e2, input logic [31:0] e3);
    return {e3, e2, e1, e0};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; sample point is 2 time units after the rising edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1; init = 1'b0; pl_update_in = 1'b0; pl_idx_in = 8'd0; pl_in = 32'd0;
    cm_rdata = 128'd0; nl_update_in = 1'b0; nl_idx_in = 8'd0; nl_in = 32'd0;
    step(); step();

    // Reset state
    chk("rst_busy", busy, 1'b0);
    chk("rst_we", cm_we, 4'b0000);
    chk("rst_pl_out", pl_out, 32'd0);
    chk("rst_ovf", ovf, 1'b0);
    chk("rst_addr", cm_addr, 8'd0);
    rst = 1'b0;

    // INIT: four rows of max sentinel
    init = 1'b1;
    step();
    init = 1'b0;
    for (int r = 0; r < 4; r++) begin
      chk("init_we", cm_we, 4'b1111);
      chk("init_wdata", cm_wdata, 32'hC000_0000);
      chk("init_addr", cm_addr, r);
      chk("init_done", init_done, (r == 3));
      chk("init_busy", busy, 1'b1);
      step();
    end
    chk("init_end_we", cm_we, 4'b0000);
    chk("init_end_busy", busy, 1'b0);
    chk("init_end_done", init_done, 1'b0);

    // Swap: idx 1, key 50 against {70,20,20,90}
    pl_update_in = 1'b1; pl_idx_in = 8'd1; pl_in = ent(16'd50);
    #1;
    chk("sw_addr_idle", cm_addr, 8'd1);
    step();
    pl_update_in = 1'b0;
    cm_rdata = row(ent(16'd70), ent(16'd20), ent(16'd20), ent(16'd90));
    chk("sw_busy", busy, 1'b1);
    chk("sw_addr_cmp", cm_addr, 8'd1);
    chk("sw_cmp_we", cm_we, 4'b0000);
    step();
    chk("sw_plu", pl_update_out, 1'b1);
    chk("sw_pl_out", pl_out, ent(16'd20));
    chk("sw_pl_idx", pl_idx_out, 8'd1);
    chk("sw_we", cm_we, 4'b0010);
    chk("sw_wdata", cm_wdata, ent(16'd50));
    chk("sw_nlu", nl_update_out, 1'b1);
    chk("sw_nl_out", nl_out, ent(16'd50));
    chk("sw_nl_idx", nl_idx_out, 8'd5);
    step();
    chk("sw_after_we", cm_we, 4'b0000);
    chk("sw_after_plu", pl_update_out, 1'b0);
    chk("sw_after_hold", pl_out, ent(16'd20));
    chk("sw_after_busy", busy, 1'b0);

    // No swap: key 10 against {30,40,50,60}
    pl_update_in = 1'b1; pl_idx_in = 8'd2; pl_in = ent(16'd10);
    step();
    pl_update_in = 1'b0;
    cm_rdata = row(ent(16'd30), ent(16'd40), ent(16'd50), ent(16'd60));
    step();
    chk("ns_plu", pl_update_out, 1'b0);
    chk("ns_nlu", nl_update_out, 1'b0);
    chk("ns_we", cm_we, 4'b0000);
    chk("ns_hold", pl_out, ent(16'd20));
    step();

    // Sentinels: min sentinel in slot 2 beats normal keys; flag 10 acts as max
    pl_update_in = 1'b1; pl_idx_in = 8'd0; pl_in = ent(16'd10);
    step();
    pl_update_in = 1'b0;
    cm_rdata = row(ent(16'd50), ent(16'd60), 32'h4000_0000, 32'h8000_0000);
    step();
    chk("sn_we", cm_we, 4'b0100);
    chk("sn_pl_out", pl_out, 32'h4000_0000);
    chk("sn_nl_idx", nl_idx_out, 8'd2);
    step();

    // Same-cycle forward: nl write-back to child 6 (row 1 slot 2) key 5
    pl_update_in = 1'b1; pl_idx_in = 8'd1; pl_in = ent(16'd50);
    step();
    pl_update_in = 1'b0;
    cm_rdata = row(ent(16'd80), ent(16'd80), ent(16'd80), ent(16'd80));
    nl_update_in = 1'b1; nl_idx_in = 8'd6; nl_in = ent(16'd5);
    step();
    nl_update_in = 1'b0;
    chk("fw_we", cm_we, 4'b0100);
    chk("fw_pl_out", pl_out, ent(16'd5));
    chk("fw_nl_idx", nl_idx_out, 8'd6);
    step();

    // Bypass: write-back to child 4 (row 1 slot 0) lands during capture cycle
    pl_update_in = 1'b1; pl_idx_in = 8'd1; pl_in = ent(16'd50);
    nl_update_in = 1'b1; nl_idx_in = 8'd4; nl_in = ent(16'd3);
    step();
    pl_update_in = 1'b0; nl_update_in = 1'b0;
    cm_rdata = row(ent(16'd80), ent(16'd80), ent(16'd80), ent(16'd80));
    step();
    chk("by_we", cm_we, 4'b0001);
    chk("by_pl_out", pl_out, ent(16'd3));
    chk("by_nl_idx", nl_idx_out, 8'd4);
    step();

    // Overflow: second pl_update_in one cycle after the first is dropped
    chk("ov_pre", ovf, 1'b0);
    pl_update_in = 1'b1; pl_idx_in = 8'd1; pl_in = ent(16'd50);
    step();
    pl_idx_in = 8'd3; pl_in = ent(16'd1);
    cm_rdata = row(ent(16'd70), ent(16'd20), ent(16'd20), ent(16'd90));
    step();
    pl_update_in = 1'b0;
    chk("ov_flag", ovf, 1'b1);
    chk("ov_pl_out", pl_out, ent(16'd20));
    chk("ov_pl_idx", pl_idx_out, 8'd1);
    chk("ov_we", cm_we, 4'b0010);
    chk("ov_wdata", cm_wdata, ent(16'd50));
    chk("ov_nl_idx", nl_idx_out, 8'd5);
    step();
    chk("ov_sticky", ovf, 1'b1);
    chk("ov_idle", busy, 1'b0);

    // Reset during CMP: nothing written, outputs cleared
    pl_update_in = 1'b1; pl_idx_in = 8'd1; pl_in = ent(16'd50);
    step();
    pl_update_in = 1'b0;
    cm_rdata = row(ent(16'd70), ent(16'd20), ent(16'd20), ent(16'd90));
    rst = 1'b1;
    #1;
    chk("rc_ovf", ovf, 1'b0);
    chk("rc_busy", busy, 1'b0);
    chk("rc_pl_out", pl_out, 32'd0);
    chk("rc_nl_out", nl_out, 32'd0);
    step();
    chk("rc_we", cm_we, 4'b0000);
    chk("rc_plu", pl_update_out, 1'b0);
    chk("rc_nlu", nl_update_out, 1'b0);

    // Release reset; the first request is taken on the next edge
    rst = 1'b0;
    pl_update_in = 1'b1; pl_idx_in = 8'd1; pl_in = ent(16'd50);
    step();
    pl_update_in = 1'b0;
    chk("rr_busy", busy, 1'b1);
    step();
    chk("rr_we", cm_we, 4'b0010);
    chk("rr_pl_out", pl_out, ent(16'd20));
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
